// File: rtl/fetch_line_buffer.sv
// Instruction fetch line buffer: requests one 16-byte line, then issues its four
// 32-bit little-endian instructions to decode, handling line advance and redirects.
module fetch_line_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         CLk,
  input  logic         reset_n,
  output logic         line_req,
  output logic [31:0]  line_addr,
  input  logic         line_valid,
  input  logic [127:0] line_data,
  output logic [31:0]  inst,
  output logic [31:0]  inst_pc,
  output logic         inst_valid,
  input  logic         inst_ready,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc
);

  typedef enum logic [1:0] {FLUSH, FETCH, ISSUE} state_t;

  localparam logic [31:0] RESET_BASE  = RESET_PC & ~32'hF;
  localparam logic [1:0]  RESET_START = RESET_PC[3:2];

  state_t         r_state, w_state_nxt;
  logic [127:0]   r_buf,   w_buf_nxt;
  logic [31:0]    r_base,  w_base_nxt;
  logic [1:0]     r_slot,  w_slot_nxt;
  logic [1:0]     r_start, w_start_nxt;
  logic [3:0][31:0] w_words;

  assign w_words = r_buf;

  always_ff @(posedge CLk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FLUSH;
      r_buf   <= '0;
      r_base  <= RESET_BASE;
      r_slot  <= '0;
      r_start <= RESET_START;
    end else begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      r_base  <= w_base_nxt;
      r_slot  <= w_slot_nxt;
      r_start <= w_start_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_base_nxt  = r_base;
    w_slot_nxt  = r_slot;
    w_start_nxt = r_start;
    case (r_state)
      FLUSH: w_state_nxt = FETCH;
      FETCH: begin
        if (line_valid) begin
          w_buf_nxt   = line_data;
          w_slot_nxt  = r_start;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (inst_ready) begin
          if (r_slot != 2'd3) begin
            w_slot_nxt = r_slot + 2'd1;
          end else begin
            w_base_nxt  = r_base + 32'd16;
            w_start_nxt = 2'd0;
            w_state_nxt = FETCH;
          end
        end
      end
      default: w_state_nxt = FLUSH;
    endcase
    // Redirect overrides everything above, including a same-cycle line or accept.
    if (redirect) begin
      w_state_nxt = FLUSH;
      w_base_nxt  = redirect_pc & ~32'hF;
      w_start_nxt = redirect_pc[3:2];
      w_slot_nxt  = r_slot;
      w_buf_nxt   = r_buf;
    end
  end

  assign line_req   = (r_state == FETCH);
  assign inst_valid = (r_state == ISSUE);
  assign line_addr  = r_base;
  assign inst       = inst_valid ? w_words[r_slot] : '0;
  assign inst_pc    = inst_valid ? (r_base | {28'd0, r_slot, 2'b00}) : '0;

endmodule
